seq_detector_param: RTL and testbench

Parametrised serial pattern detector; successor to the fixed "101" detector. Supports:
- a runtime-loadable pattern of 1..MAX_W bits,
- selectable overlapping or non-overlapping matching,
- an input-valid qualifier,
- a saturating match counter.

It sits behind a serial receiver and flags framing/sync words for downstream logic.

---
 rtl/seq_det_pkg.sv | 35 +++
 rtl/seq_detector_param_sat_counter.sv | 34 +++
 rtl/seq_detector_param.sv | 149 ++++++++++++++
 tb/tb_seq_detector_param.sv | 213 +++++++++++++++++++++
 4 files changed

// File: rtl/seq_det_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : seq_det_pkg
//  Description : Shared types and helpers for the parametrised serial
//                pattern detector (state encoding, length width, bit mask).
//  Revision    : 1.0  initial release
// ============================================================================
package seq_det_pkg;

    // Detector states: collecting fresh bits, or comparing every bit
    typedef enum logic [0:0] {
        ST_FILL  = 1'b0,
        ST_ARMED = 1'b1
    } state_t;

    // Widest pattern the mask helper can describe
    localparam int c_MASK_W = 32;

    // Number of bits needed to hold a length value 0..max_w
    function automatic int len_w(input int max_w);
        return $clog2(max_w + 1);
    endfunction

    // Mask with the low 'len' bits set; bits above the pattern are ignored
    function automatic logic [c_MASK_W-1:0] len_mask(input int len);
        logic [c_MASK_W-1:0] m;
        m = '0;
        for (int i = 0; i < c_MASK_W; i++) begin
            m[i] = (i < len);
        end
        return m;
    endfunction

endpackage : seq_det_pkg
`default_nettype wire

// File: rtl/seq_detector_param_sat_counter.sv
`default_nettype none
// ============================================================================
//  Module      : sat_counter
//  Description : Saturating up-counter with synchronous clear. Clear has
//                priority over increment; the count never wraps.
//  Revision    : 1.0  initial release
// ============================================================================
module sat_counter #(
    parameter int COUNT_W = 8
) (
    input  logic               clock,
    input  logic               reset,
    input  logic               inc,
    input  logic               clr,
    output logic [COUNT_W-1:0] count
);

    logic [COUNT_W-1:0] r_count;

    // Count increments, held at all-ones once full; clear wins over increment
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_count <= '0;
        end else if (clr) begin
            r_count <= '0;
        end else if (inc && (r_count != {COUNT_W{1'b1}})) begin
            r_count <= r_count + 1'b1;
        end
    end

    assign count = r_count;

endmodule : sat_counter
`default_nettype wire

// File: rtl/seq_detector_param.sv
`default_nettype none
// ============================================================================
//  Module      : seq_detector_param
//  Description : Serial pattern detector with a runtime-loadable pattern of
//                1..MAX_W bits, overlapping / non-overlapping matching, an
//                input-valid qualifier and a saturating match counter.
//  Revision    : 1.0  initial release
// ============================================================================
module seq_detector_param
    import seq_det_pkg::*;
#(
    parameter int               MAX_W           = 8,
    parameter logic [MAX_W-1:0] DEFAULT_PATTERN = 8'b0000_0101,
    parameter int               DEFAULT_LEN     = 3,
    parameter logic             DEFAULT_OVERLAP = 1'b1,
    parameter int               COUNT_W         = 8
) (
    input  logic                       clock,
    input  logic                       reset,
    input  logic                       serial_in,
    input  logic                       in_valid,
    input  logic                       cfg_load,
    input  logic [MAX_W-1:0]           cfg_pattern,
    input  logic [$clog2(MAX_W+1)-1:0] cfg_len,
    input  logic                       cfg_overlap,
    input  logic                       count_clear,
    output logic                       detect,
    output logic [COUNT_W-1:0]         match_count,
    output logic                       armed
);

    localparam int                 c_LEN_W   = len_w(MAX_W);
    localparam logic [c_LEN_W-1:0] c_MAX_LEN = c_LEN_W'(MAX_W);
    localparam logic [c_LEN_W-1:0] c_DEF_LEN = c_LEN_W'(DEFAULT_LEN);

    // Active configuration
    logic [MAX_W-1:0]   r_pattern;
    logic [c_LEN_W-1:0] r_len;
    logic               r_overlap;

    // Shift history, fill progress, state and registered detect pulse
    logic [MAX_W-1:0]   r_history;
    logic [c_LEN_W-1:0] r_fill_cnt;
    state_t             r_state;
    logic               r_detect;

    logic [MAX_W-1:0]    w_hist_shift;
    logic [MAX_W-1:0]    w_hist_next;
    logic [c_LEN_W-1:0]  w_fill_inc;
    logic [c_LEN_W-1:0]  w_fill_next;
    state_t              w_state_next;
    logic                w_detect_next;
    logic                w_match;
    logic [c_MASK_W-1:0] w_mask;
    logic [c_LEN_W-1:0]  w_cfg_len;

    // Out-of-range lengths (0 or above MAX_W) fall back to the full width
    assign w_cfg_len = ((cfg_len == '0) || (cfg_len > c_MAX_LEN)) ? c_MAX_LEN : cfg_len;

    // Only the low r_len bits take part in the comparison
    assign w_mask       = len_mask(int'(r_len));
    assign w_hist_shift = {r_history[MAX_W-2:0], serial_in};
    assign w_match      = ((c_MASK_W'(w_hist_shift ^ r_pattern)) & w_mask) == '0;
    assign w_fill_inc   = r_fill_cnt + 1'b1;

    // Next-state, history and detect decisions; cfg_load discards the current bit
    always_comb begin
        w_state_next  = r_state;
        w_fill_next   = r_fill_cnt;
        w_hist_next   = r_history;
        w_detect_next = 1'b0;

        if (cfg_load) begin
            w_state_next = ST_FILL;
            w_fill_next  = '0;
            w_hist_next  = '0;
        end else if (in_valid) begin
            w_hist_next = w_hist_shift;
            case (r_state)
                ST_FILL: begin
                    if (w_fill_inc == r_len) begin
                        w_detect_next = w_match;
                        // A non-overlapping match on the filling bit needs len fresh bits again
                        if (w_match && !r_overlap) begin
                            w_state_next = ST_FILL;
                            w_fill_next  = '0;
                        end else begin
                            w_state_next = ST_ARMED;
                            w_fill_next  = w_fill_inc;
                        end
                    end else begin
                        w_fill_next = w_fill_inc;
                    end
                end
                ST_ARMED: begin
                    if (w_match) begin
                        w_detect_next = 1'b1;
                        if (!r_overlap) begin
                            w_state_next = ST_FILL;
                            w_fill_next  = '0;
                        end
                    end
                end
                default: begin
                    w_state_next = ST_FILL;
                    w_fill_next  = '0;
                end
            endcase
        end
    end

    // State, history, detect and configuration registers
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_state    <= ST_FILL;
            r_fill_cnt <= '0;
            r_history  <= '0;
            r_detect   <= 1'b0;
            r_pattern  <= DEFAULT_PATTERN;
            r_len      <= c_DEF_LEN;
            r_overlap  <= DEFAULT_OVERLAP;
        end else begin
            r_state    <= w_state_next;
            r_fill_cnt <= w_fill_next;
            r_history  <= w_hist_next;
            r_detect   <= w_detect_next;
            if (cfg_load) begin
                r_pattern <= cfg_pattern;
                r_len     <= w_cfg_len;
                r_overlap <= cfg_overlap;
            end
        end
    end

    sat_counter #(
        .COUNT_W (COUNT_W)
    ) u_match_cnt (
        .clock (clock),
        .reset (reset),
        .inc   (w_detect_next),
        .clr   (count_clear),
        .count (match_count)
    );

    assign detect = r_detect;
    assign armed  = (r_state == ST_ARMED);

endmodule : seq_detector_param
`default_nettype wire

// File: tb/tb_seq_detector_param.sv
`default_nettype none
// ============================================================================
//  Module      : tb_seq_detector_param
//  Description : Self-checking bench for seq_detector_param (COUNT_W = 2 so
//                that counter saturation is reachable in a few matches).
//  Revision    : 1.0  initial release
// ============================================================================
module tb_seq_detector_param;

    logic       clock = 1'b0;
    logic       reset;
    logic       serial_in;
    logic       in_valid;
    logic       cfg_load;
    logic [7:0] cfg_pattern;
    logic [3:0] cfg_len;
    logic       cfg_overlap;
    logic       count_clear;
    logic       detect;
    logic [1:0] match_count;
    logic       armed;

    seq_detector_param #(
        .MAX_W           (8),
        .DEFAULT_PATTERN (8'b0000_0101),
        .DEFAULT_LEN     (3),
        .DEFAULT_OVERLAP (1'b1),
        .COUNT_W         (2)
    ) dut (
        .clock       (clock),
        .reset       (reset),
        .serial_in   (serial_in),
        .in_valid    (in_valid),
        .cfg_load    (cfg_load),
        .cfg_pattern (cfg_pattern),
        .cfg_len     (cfg_len),
        .cfg_overlap (cfg_overlap),
        .count_clear (count_clear),
        .detect      (detect),
        .match_count (match_count),
        .armed       (armed)
    );

    always #5 clock = ~clock;

    typedef struct packed {
        logic v;
        logic b;
        logic det;
        logic arm;
    } vec_t;

    typedef struct packed {
        logic       det;
        logic [1:0] cnt;
        logic       arm;
    } exp_t;

    exp_t       sb_q[$];
    vec_t       t1[16];
    logic [1:0] m_cnt;
    int         n_vec;
    int         n_err;

    task automatic chk(input string name, input logic [7:0] act, input logic [7:0] req);
        n_vec++;
        if (act !== req) begin
            n_err++;
            $display("FAIL %s: got %0d, expected %0d", name, act, req);
        end
    endtask

    task automatic set_cfg(input logic [7:0] pat, input logic [3:0] len, input logic ov);
        cfg_pattern = pat;
        cfg_len     = len;
        cfg_overlap = ov;
    endtask

    // Drive one cycle, push the expectation, then pop and compare after the edge
    task automatic step(input logic v, input logic b, input logic ld, input logic clr,
                        input logic edet, input logic earm, input string tag);
        exp_t e;
        in_valid    = v;
        serial_in   = b;
        cfg_load    = ld;
        count_clear = clr;
        if (clr)
            m_cnt = 2'd0;
        else if (edet && (m_cnt != 2'd3))
            m_cnt = m_cnt + 2'd1;
        e.det = edet;
        e.cnt = m_cnt;
        e.arm = earm;
        sb_q.push_back(e);
        @(posedge clock);
        #1;
        in_valid    = 1'b0;
        cfg_load    = 1'b0;
        count_clear = 1'b0;
        e = sb_q.pop_front();
        chk({tag, " detect"}, 8'(detect), 8'(e.det));
        chk({tag, " count"},  8'(match_count), 8'(e.cnt));
        chk({tag, " armed"},  8'(armed), 8'(e.arm));
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: got timeout, expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        logic [15:0] s1;
        logic [7:0]  byte_b1;
        n_vec = 0;
        n_err = 0;
        m_cnt = 2'd0;
        reset = 1'b1;
        serial_in = 1'b0;
        in_valid = 1'b0;
        cfg_load = 1'b0;
        count_clear = 1'b0;
        set_cfg(8'h05, 4'd3, 1'b1);

        // Test 1 table: default 101 pattern, detects after bits 3, 6, 11
        s1 = 16'b1101_1010_0101_0010;
        for (int i = 0; i < 16; i++) begin
            t1[i].v   = 1'b1;
            t1[i].b   = s1[15-i];
            t1[i].det = (i == 3) || (i == 6) || (i == 11);
            t1[i].arm = (i >= 2);
        end

        // Reset state
        @(posedge clock);
        #1;
        chk("reset detect", 8'(detect), 8'd0);
        chk("reset count",  8'(match_count), 8'd0);
        chk("reset armed",  8'(armed), 8'd0);
        reset = 1'b0;

        // Test 1
        for (int i = 0; i < 16; i++)
            step(t1[i].v, t1[i].b, 1'b0, 1'b0, t1[i].det, t1[i].arm, $sformatf("t1[%0d]", i));

        // Test 5: history ends ...0,1,0 so feeding 1 completes 101, then 0
        step(1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1, "t5 pre1");
        step(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, "t5 pre0");
        #2 reset = 1'b1;
        #1;
        chk("t5 async detect", 8'(detect), 8'd0);
        chk("t5 async count",  8'(match_count), 8'd0);
        chk("t5 async armed",  8'(armed), 8'd0);
        m_cnt = 2'd0;
        #1 reset = 1'b0;
        step(1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, "t5 b0");
        step(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, "t5 b1");
        step(1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1, "t5 b2");

        // Test 2: overlap on 1,0,1,0,1
        set_cfg(8'h05, 4'd3, 1'b1);
        step(1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, "t2 load ov");
        for (int i = 0; i < 5; i++)
            step(1'b1, ((i % 2) == 0), 1'b0, 1'b0, (i == 2) || (i == 4), (i >= 2),
                 $sformatf("t2 ov[%0d]", i));
        // Non-overlap on the same stream
        set_cfg(8'h05, 4'd3, 1'b0);
        step(1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, "t2 load nov");
        for (int i = 0; i < 5; i++)
            step(1'b1, ((i % 2) == 0), 1'b0, 1'b0, (i == 2), 1'b0,
                 $sformatf("t2 nov[%0d]", i));

        // Test 3: 8-bit pattern, MSB first, contiguous then with idle gaps
        byte_b1 = 8'b1011_0001;
        set_cfg(byte_b1, 4'd8, 1'b1);
        step(1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, "t3 load");
        for (int i = 0; i < 8; i++)
            step(1'b1, byte_b1[7-i], 1'b0, 1'b0, (i == 7), (i == 7), $sformatf("t3 b[%0d]", i));
        set_cfg(byte_b1, 4'd0, 1'b1);
        step(1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, "t3 load len0");
        for (int i = 0; i < 8; i++) begin
            step(1'b1, byte_b1[7-i], 1'b0, 1'b0, (i == 7), (i == 7), $sformatf("t3g b[%0d]", i));
            for (int k = 0; k < 3; k++)
                step(1'b0, 1'b1, 1'b0, 1'b0, 1'b0, (i == 7), $sformatf("t3g idle[%0d.%0d]", i, k));
        end

        // Test 4: len 1, saturation at 3, clear beats coincident match
        set_cfg(8'h01, 4'd1, 1'b1);
        step(1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, "t4 load");
        for (int i = 0; i < 6; i++)
            step(1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1, $sformatf("t4 sat[%0d]", i));
        step(1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 1'b1, "t4 clr+match");
        step(1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, "t4 idle");
        step(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, "t4 zero");

        // Test 6: cfg_load on the bit that would complete a match
        set_cfg(8'h05, 4'd3, 1'b1);
        step(1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, "t6 load");
        step(1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, "t6 a0");
        step(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, "t6 a1");
        step(1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1, "t6 a2");
        step(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, "t6 a3");
        step(1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, "t6 load+match");
        step(1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, "t6 b0");
        step(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, "t6 b1");
        step(1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1, "t6 b2");

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule : tb_seq_detector_param
`default_nettype wire
